instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of the target instruction memory (2^ADDR_W bytes).
REQ-002 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  one-cycle request to begin a load session.
REQ-005 BASE_ADDR  input  ADDR_W  first byte address of the session; bits [1:0] ignored (forced 00).
REQ-006 WORD_IN  input  32  instruction word to store.
REQ-007 WORD_VALID  input  1  WORD_IN valid.
REQ-008 WORD_LAST  input  1  qualifies WORD_IN as final word of session.
REQ-009 WORD_READY  output  1  loader accepts WORD_IN this cycle.
REQ-010 MEM_WE  output  1  byte write strobe to instruction memory.
REQ-011 MEM_ADDR  output  ADDR_W  byte write address.
REQ-012 MEM_WDATA  output  8  byte write data.
REQ-013 BUSY  output  1  session in progress; CPU_HOLD  output  1  equals BUSY, holds PC/core in reset.
REQ-014 DONE  output  1  one-cycle pulse at session end; OVERFLOW  output  1  session ran past memory end.

Function
REQ-015 States: IDLE, WAIT_WORD, WRITE, FINISH; IDLE after reset.
REQ-016 IDLE: START=1 -> WAIT_WORD next cycle, pointer <= {1'b0, BASE_ADDR[ADDR_W-1:2], 2'b00} (ADDR_W+1 bits), OVERFLOW cleared, BUSY=1.
REQ-017 IDLE: WORD_VALID ignored, WORD_READY=0; START in any other state ignored.
REQ-018 WAIT_WORD: WORD_READY=1 iff pointer < 2^ADDR_W; transfer occurs on edge with WORD_VALID & WORD_READY; word and WORD_LAST latched, -> WRITE.
REQ-019 WAIT_WORD with pointer = 2^ADDR_W: WORD_READY=0, OVERFLOW<=1 (sticky until next START), -> FINISH; no memory write.
REQ-020 WRITE: exactly 4 consecutive cycles, MEM_WE=1, byte k (k=0..3) at MEM_ADDR=pointer+k, MEM_WDATA=word[8k+7:8k] (little-endian, low byte at low address).
REQ-021 Latency: word accepted at edge N -> MEM_WE high for cycles N+1..N+4; WORD_READY=0 throughout WRITE; max throughput 1 word / 5 cycles.
REQ-022 After byte 3: pointer += 4; latched WORD_LAST=1 -> FINISH, else -> WAIT_WORD.
REQ-023 FINISH: one cycle, DONE=1, BUSY/CPU_HOLD still 1; -> IDLE, BUSY=0 next cycle.
REQ-024 MEM_WE=0 in every state except WRITE; MEM_ADDR/MEM_WDATA hold last values when MEM_WE=0.

Reset
REQ-025 RESET=1 at an edge forces IDLE regardless of state, including mid-WRITE; no further MEM_WE after that edge.
REQ-026 Reset values: WORD_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, BUSY=0, CPU_HOLD=0, DONE=0, OVERFLOW=0, pointer=0, CHECKSUM=0 (when present).
REQ-027 RESET has priority over START in the same cycle.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: output CHECKSUM[7:0] present; mod-256 sum of every byte written this session, cleared on accepted START, updated on each MEM_WE cycle, valid when DONE=1.
REQ-029 LOADER_CHECKSUM_EN undefined: CHECKSUM port and its logic absent; all other behaviour identical.

Verification
REQ-030 Reset, START base 0, WORD_IN=0x00100108 LAST=1 -> writes addr0=0x08, 1=0x01, 2=0x10, 3=0x00; DONE pulse; BUSY=0 next cycle.
REQ-031 START base 0, six words WORD_VALID held high, last flagged -> bytes at addr 0..23 in order, WORD_READY low 4 cycles between accepts, one DONE.
REQ-032 ADDR_W=10, BASE_ADDR=0x3FE, two words non-LAST -> first written 0x3FC..0x3FF, second never accepted, OVERFLOW=1, DONE pulse.
REQ-033 RESET asserted during byte 2 of a word -> MEM_WE=0 from next cycle, BUSY=0, state IDLE, no further writes.
REQ-034 START during BUSY and WORD_VALID in IDLE -> both ignored, no writes, pointer unchanged.
REQ-035 With LOADER_CHECKSUM_EN: words 0x00100108, 0x00286400 (LAST) -> CHECKSUM=0xA5 at DONE.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, holding the core while loading.
// Optional LOADER_CHECKSUM_EN adds a mod-256 CHECKSUM output over the bytes written in a session.
module instr_mem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [31:0]       WORD_IN,
  input  logic              WORD_VALID,
  input  logic              WORD_LAST,
  output logic              WORD_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  output logic              BUSY,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              OVERFLOW
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        CHECKSUM
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, FINISH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   ptr;        // extra MSB flags "one past the end of memory"
  logic [31:0]       word_q;
  logic              last_q;
  logic [1:0]        byte_idx;
  logic              ovf_q;
  logic [ADDR_W-1:0] addr_hold;
  logic [7:0]        data_hold;
  logic              start_go, accept, ovf_set;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_byte;

  assign cur_addr = ptr[ADDR_W-1:0] + ADDR_W'(byte_idx);
  assign cur_byte = word_q[{byte_idx, 3'b000} +: 8];

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    WORD_READY = 1'b0;
    MEM_WE     = 1'b0;
    BUSY       = 1'b1;
    DONE       = 1'b0;
    start_go   = 1'b0;
    accept     = 1'b0;
    ovf_set    = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          start_go  = 1'b1;
          state_nxt = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (ptr[ADDR_W]) begin
          ovf_set   = 1'b1;
          state_nxt = FINISH;
        end else begin
          WORD_READY = 1'b1;
          if (WORD_VALID) begin
            accept    = 1'b1;
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        MEM_WE = 1'b1;
        if (byte_idx == 2'd3) state_nxt = last_q ? FINISH : WAIT_WORD;
      end
      FINISH: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are driven live during WRITE and otherwise hold the last byte written.
  assign MEM_ADDR  = MEM_WE ? cur_addr : addr_hold;
  assign MEM_WDATA = MEM_WE ? cur_byte : data_hold;
  assign CPU_HOLD  = BUSY;
  assign OVERFLOW  = ovf_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr       <= '0;
      word_q    <= '0;
      last_q    <= 1'b0;
      byte_idx  <= '0;
      ovf_q     <= 1'b0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      if (start_go) begin
        ptr   <= {1'b0, BASE_ADDR & ~ADDR_W'(3)};
        ovf_q <= 1'b0;
      end
      if (accept) begin
        word_q   <= WORD_IN;
        last_q   <= WORD_LAST;
        byte_idx <= '0;
      end
      if (ovf_set) ovf_q <= 1'b1;
      if (MEM_WE) begin
        addr_hold <= cur_addr;
        data_hold <= cur_byte;
        byte_idx  <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) ptr <= ptr + (ADDR_W+1)'(4);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (RESET)         CHECKSUM <= '0;
    else if (start_go) CHECKSUM <= '0;
    else if (MEM_WE)   CHECKSUM <= CHECKSUM + cur_byte;
  end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: single word, streaming, overflow, mid-write reset, ignored inputs.
module tb_instr_mem_loader;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESET, START, WORD_VALID, WORD_LAST;
  logic [AW-1:0] BASE_ADDR;
  logic [31:0]   WORD_IN;
  logic          WORD_READY, MEM_WE, BUSY, CPU_HOLD, DONE, OVERFLOW;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0]    MEM_WDATA;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    CHECKSUM;
`endif

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] wlog_a[$];
  logic [7:0]    wlog_d[$];
  int done_cnt = 0;

  instr_mem_loader #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR),
    .WORD_IN(WORD_IN), .WORD_VALID(WORD_VALID), .WORD_LAST(WORD_LAST),
    .WORD_READY(WORD_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .BUSY(BUSY), .CPU_HOLD(CPU_HOLD), .DONE(DONE),
    .OVERFLOW(OVERFLOW)
`ifdef LOADER_CHECKSUM_EN
    , .CHECKSUM(CHECKSUM)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory-side monitor: every byte actually strobed into memory, and every DONE cycle.
  always @(posedge CLK) begin
    if (MEM_WE) begin
      wlog_a.push_back(MEM_ADDR);
      wlog_d.push_back(MEM_WDATA);
    end
    if (DONE) done_cnt++;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1; START = 1'b0; WORD_VALID = 1'b0; WORD_LAST = 1'b0;
    BASE_ADDR = '0; WORD_IN = '0;
    tick; tick;
    checks++;
    if ({WORD_READY, MEM_WE, BUSY, CPU_HOLD, DONE, OVERFLOW} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {WORD_READY, MEM_WE, BUSY, CPU_HOLD, DONE, OVERFLOW});
    end
    checks++;
    if (MEM_ADDR !== '0 || MEM_WDATA !== 8'h00) begin
      errors++; $display("FAIL reset_mem got addr=%h data=%h exp 0/0", MEM_ADDR, MEM_WDATA);
    end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (CHECKSUM !== 8'h00) begin
      errors++; $display("FAIL reset_checksum got=%h exp=00", CHECKSUM);
    end
`endif
    RESET = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int wb, db;
    logic [7:0] exp_b [4];
    exp_b = '{8'h08, 8'h01, 8'h10, 8'h00};
    wb = wlog_a.size(); db = done_cnt;
    START = 1'b1; BASE_ADDR = '0;
    tick;
    START = 1'b0;
    checks++;
    if ({BUSY, CPU_HOLD, WORD_READY} !== 3'b111) begin
      errors++; $display("FAIL single_wait got=%b exp=111", {BUSY, CPU_HOLD, WORD_READY});
    end
    WORD_IN = 32'h00100108; WORD_LAST = 1'b1; WORD_VALID = 1'b1;
    tick;
    WORD_VALID = 1'b0; WORD_LAST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({MEM_WE, WORD_READY, MEM_ADDR, MEM_WDATA} !== {1'b1, 1'b0, AW'(k), exp_b[k]}) begin
        errors++; $display("FAIL single_byte%0d got we=%b rdy=%b addr=%h data=%h exp we=1 rdy=0 addr=%h data=%h",
                           k, MEM_WE, WORD_READY, MEM_ADDR, MEM_WDATA, k, exp_b[k]);
      end
      tick;
    end
    checks++;
    if ({DONE, BUSY, CPU_HOLD, MEM_WE} !== 4'b1110 || MEM_ADDR !== AW'(3) || MEM_WDATA !== 8'h00) begin
      errors++; $display("FAIL single_finish got done/busy/hold/we=%b addr=%h data=%h exp 1110 003 00",
                         {DONE, BUSY, CPU_HOLD, MEM_WE}, MEM_ADDR, MEM_WDATA);
    end
    tick;
    checks++;
    if ({DONE, BUSY, CPU_HOLD} !== 3'b000) begin
      errors++; $display("FAIL single_idle got=%b exp=000", {DONE, BUSY, CPU_HOLD});
    end
    checks++;
    if (done_cnt - db != 1 || wlog_a.size() - wb != 4) begin
      errors++; $display("FAIL single_counts got done=%0d writes=%0d exp 1 4", done_cnt - db, wlog_a.size() - wb);
    end
  endtask

  task automatic test_back_to_back;
    int wb, db, i, cyc, last_acc, gap_bad, bad, n;
    logic [31:0] w;
    wb = wlog_a.size(); db = done_cnt;
    i = 0; cyc = 0; last_acc = -1; gap_bad = 0; bad = 0;
    START = 1'b1; BASE_ADDR = '0;
    tick;
    START = 1'b0;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(b);
    WORD_IN = w; WORD_LAST = 1'b0; WORD_VALID = 1'b1;
    while (i < 6 && cyc < 100) begin
      if (WORD_READY) begin
        if (last_acc >= 0 && cyc - last_acc != 5) gap_bad++;
        last_acc = cyc;
        i++;
        tick; cyc++;
        if (i < 6) begin
          for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(4*i + b);
          WORD_IN = w; WORD_LAST = (i == 5);
        end
      end else begin
        tick; cyc++;
      end
    end
    WORD_VALID = 1'b0; WORD_LAST = 1'b0;
    checks++;
    if (i != 6) begin
      errors++; $display("FAIL b2b_accepts got=%0d exp=6 (timeout)", i);
    end
    checks++;
    if (gap_bad != 0) begin
      errors++; $display("FAIL b2b_gap got=%0d bad gaps exp=0", gap_bad);
    end
    n = 0;
    while (!DONE && n < 30) begin tick; n++; end
    checks++;
    if (DONE !== 1'b1) begin
      errors++; $display("FAIL b2b_done got=%b exp=1 (timeout)", DONE);
    end
    tick;
    checks++;
    if (done_cnt - db != 1 || wlog_a.size() - wb != 24) begin
      errors++; $display("FAIL b2b_counts got done=%0d writes=%0d exp 1 24", done_cnt - db, wlog_a.size() - wb);
    end
    for (int k = 0; k < 24 && wb + k < wlog_a.size(); k++)
      if (wlog_a[wb+k] !== AW'(k) || wlog_d[wb+k] !== 8'(k)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL b2b_bytes got %0d wrong entries exp 0", bad);
    end
  endtask

  task automatic test_overflow;
    int wb, db, bad;
    wb = wlog_a.size(); db = done_cnt; bad = 0;
    START = 1'b1; BASE_ADDR = AW'(10'h3FE);
    tick;
    START = 1'b0;
    WORD_IN = 32'hDDCCBBAA; WORD_VALID = 1'b1; WORD_LAST = 1'b0;
    checks++;
    if ({WORD_READY, OVERFLOW} !== 2'b10) begin
      errors++; $display("FAIL ovf_start got rdy/ovf=%b exp=10", {WORD_READY, OVERFLOW});
    end
    tick;
    WORD_IN = 32'h11223344;
    repeat (4) tick;
    checks++;
    if ({WORD_READY, DONE} !== 2'b00) begin
      errors++; $display("FAIL ovf_end_ready got rdy/done=%b exp=00", {WORD_READY, DONE});
    end
    tick;
    checks++;
    if ({DONE, OVERFLOW, BUSY} !== 3'b111) begin
      errors++; $display("FAIL ovf_finish got done/ovf/busy=%b exp=111", {DONE, OVERFLOW, BUSY});
    end
    WORD_VALID = 1'b0;
    tick;
    checks++;
    if ({OVERFLOW, BUSY} !== 2'b10) begin
      errors++; $display("FAIL ovf_sticky got ovf/busy=%b exp=10", {OVERFLOW, BUSY});
    end
    for (int k = 0; k < 4 && wb + k < wlog_a.size(); k++)
      if (wlog_a[wb+k] !== AW'(10'h3FC + k) || wlog_d[wb+k] !== 8'(8'hAA + 8'h11 * k)) bad++;
    checks++;
    if (wlog_a.size() - wb != 4 || bad != 0 || done_cnt - db != 1) begin
      errors++; $display("FAIL ovf_writes got writes=%0d bad=%0d done=%0d exp 4 0 1", wlog_a.size() - wb, bad, done_cnt - db);
    end
  endtask

  task automatic test_reset_mid;
    int wb;
    wb = wlog_a.size();
    START = 1'b1; BASE_ADDR = AW'(10'h010);
    tick;
    START = 1'b0;
    WORD_IN = 32'hAABBCCDD; WORD_LAST = 1'b1; WORD_VALID = 1'b1;
    tick;
    WORD_VALID = 1'b0; WORD_LAST = 1'b0;
    tick; tick;
    checks++;
    if ({MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, AW'(10'h012), 8'hBB}) begin
      errors++; $display("FAIL rmid_byte2 got we=%b addr=%h data=%h exp 1 012 bb", MEM_WE, MEM_ADDR, MEM_WDATA);
    end
    RESET = 1'b1;
    tick;
    checks++;
    if ({MEM_WE, BUSY, CPU_HOLD, WORD_READY, DONE, OVERFLOW} !== 6'b0) begin
      errors++; $display("FAIL rmid_ctrl got=%b exp=000000", {MEM_WE, BUSY, CPU_HOLD, WORD_READY, DONE, OVERFLOW});
    end
    checks++;
    if (MEM_ADDR !== '0 || MEM_WDATA !== 8'h00) begin
      errors++; $display("FAIL rmid_mem got addr=%h data=%h exp 0/0", MEM_ADDR, MEM_WDATA);
    end
    RESET = 1'b0;
    repeat (6) tick;
    checks++;
    if ({MEM_WE, BUSY} !== 2'b00 || wlog_a.size() - wb != 3) begin
      errors++; $display("FAIL rmid_after got we/busy=%b writes=%0d exp 00 3", {MEM_WE, BUSY}, wlog_a.size() - wb);
    end
  endtask

  task automatic test_ignored;
    int wb, n, bad;
    wb = wlog_a.size(); bad = 0;
    WORD_IN = 32'h12345678; WORD_VALID = 1'b1; WORD_LAST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({WORD_READY, BUSY} !== 2'b00) begin
        errors++; $display("FAIL ign_idle%0d got rdy/busy=%b exp=00", k, {WORD_READY, BUSY});
      end
      tick;
    end
    WORD_VALID = 1'b0;
    START = 1'b1; BASE_ADDR = AW'(10'h020);
    tick;
    BASE_ADDR = AW'(10'h100);
    WORD_IN = 32'h44332211; WORD_VALID = 1'b1; WORD_LAST = 1'b1;
    tick;
    START = 1'b0; WORD_VALID = 1'b0; WORD_LAST = 1'b0;
    checks++;
    if ({MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, AW'(10'h020), 8'h11}) begin
      errors++; $display("FAIL ign_first got we=%b addr=%h data=%h exp 1 020 11", MEM_WE, MEM_ADDR, MEM_WDATA);
    end
    n = 0;
    while (!DONE && n < 30) begin tick; n++; end
    checks++;
    if (DONE !== 1'b1) begin
      errors++; $display("FAIL ign_done got=%b exp=1 (timeout)", DONE);
    end
    tick;
    for (int k = 0; k < 4 && wb + k < wlog_a.size(); k++)
      if (wlog_a[wb+k] !== AW'(10'h020 + k) || wlog_d[wb+k] !== 8'(8'h11 * (k + 1))) bad++;
    checks++;
    if (wlog_a.size() - wb != 4 || bad != 0) begin
      errors++; $display("FAIL ign_writes got writes=%0d bad=%0d exp 4 0", wlog_a.size() - wb, bad);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int i, n;
    i = 0; n = 0;
    START = 1'b1; BASE_ADDR = '0;
    tick;
    START = 1'b0;
    WORD_IN = 32'h00100108; WORD_LAST = 1'b0; WORD_VALID = 1'b1;
    while (i < 2 && n < 40) begin
      if (WORD_READY) begin
        i++;
        tick; n++;
        WORD_IN = 32'h00286400; WORD_LAST = 1'b1;
      end else begin
        tick; n++;
      end
    end
    WORD_VALID = 1'b0; WORD_LAST = 1'b0;
    n = 0;
    while (!DONE && n < 30) begin tick; n++; end
    checks++;
    if (DONE !== 1'b1 || CHECKSUM !== 8'hA5) begin
      errors++; $display("FAIL checksum got done=%b sum=%h exp 1 a5", DONE, CHECKSUM);
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    test_ignored;
`ifdef LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
